// File: rtl/ov_dvp_capture.sv
// ---------------------------------------------------------------------------
// ov_dvp_capture
//   Captures frames from an OmniVision style DVP sensor bus (vsync/href/data)
//   and assembles DATA_W-bit bytes into DATA_W*BPP-bit pixels, with frame and
//   line markers, framing-error detection and post-reset settling-frame skip.
//
// Ports
//   clk          in   pixel clock, sole clock
//   rst_n        in   synchronous active-low reset
//   i_en         in   capture enable, sampled only at the vsync falling edge
//   i_data       in   DVP byte
//   href         in   line valid, active high
//   vsync        in   frame sync, active high between frames
//   o_pix        out  assembled pixel, held until the next valid
//   o_pix_vld    out  o_pix valid strobe
//   o_sof        out  first pixel of frame (line 0, pixel 0)
//   o_eol        out  last pixel of a line (index IMG_W-1)
//   o_eof        out  last pixel of a frame
//   o_err        out  one-cycle framing-error pulse
//   o_err_cnt    out  saturating error count
//   o_frame_cnt  out  completed frame count, wraps
//
// Handshake: o_pix_vld is a one-cycle valid strobe with no ready; a consumer
// must accept the pixel on every cycle o_pix_vld is high. o_sof/o_eol/o_eof
// are only meaningful while o_pix_vld is high.
//
// The FSM state is held in state_q (state_e) for checkers to bind to.
// ---------------------------------------------------------------------------
module ov_dvp_capture #(
  parameter int DATA_W      = 8,
  parameter int BPP         = 2,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  href,
  input  logic                  vsync,
  output logic [DATA_W*BPP-1:0] o_pix,
  output logic                  o_pix_vld,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_eof,
  output logic                  o_err,
  output logic [7:0]            o_err_cnt,
  output logic [15:0]           o_frame_cnt
);

  localparam int PIX_W = DATA_W * BPP;
  // Counters saturate one past the last legal index, so they need room for it.
  localparam int PCW = $clog2(IMG_W + 1);
  localparam int LCW = $clog2(IMG_H + 1);
  localparam int SCW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [PCW-1:0] PIX_LAST  = PCW'(IMG_W - 1);
  localparam logic [PCW-1:0] PIX_END   = PCW'(IMG_W);
  localparam logic [LCW-1:0] LINE_LAST = LCW'(IMG_H - 1);
  localparam logic [LCW-1:0] LINE_END  = LCW'(IMG_H);
  localparam logic [SCW-1:0] SKIP_MAX  = SCW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_CAPTURE  = 2'd2,
    S_DROP     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               vsync_q;
  logic               line_act_q, line_act_d;   // href seen high in this line
  logic               phase_q, phase_d;         // high byte of a pixel pending
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [PCW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [LCW-1:0]     line_cnt_q, line_cnt_d;
  logic [SCW-1:0]     skip_q, skip_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               vld_q, vld_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;
  logic               err_q, err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               vsync_fall;
  logic [PIX_W-1:0]   pix_new;
  logic               pix_done;
  logic               err_evt;

  assign vsync_fall = vsync_q & ~vsync;

  // High byte arrives first on the bus in two-byte mode.
  if (BPP == 2) begin : g_bpp2
    assign pix_new = {hi_q, i_data};
  end else begin : g_bpp1
    assign pix_new = i_data;
  end

  always_comb begin
    state_d     = state_q;
    line_act_d  = line_act_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    skip_d      = skip_q;
    pix_d       = pix_q;
    vld_d       = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    eof_d       = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pix_done    = 1'b0;
    err_evt     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vsync) state_d = S_WAIT_SOF;
      end

      S_WAIT_SOF: begin
        if (vsync_fall) begin
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          phase_d    = 1'b0;
          line_act_d = 1'b0;
          if ((skip_q < SKIP_MAX) || !i_en) state_d = S_DROP;
          else                               state_d = S_CAPTURE;
        end
      end

      S_DROP: begin
        if (vsync) begin
          state_d = S_WAIT_SOF;
          if (skip_q < SKIP_MAX) skip_d = skip_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        if (vsync) begin
          // vsync has priority over a coincident href byte, which is lost.
          state_d    = S_WAIT_SOF;
          line_act_d = 1'b0;
          phase_d    = 1'b0;
          if (line_cnt_q < LINE_END) err_evt = 1'b1;
        end else if (href) begin
          line_act_d = 1'b1;
          if (BPP == 1) begin
            pix_done = 1'b1;
          end else if (!phase_q) begin
            hi_d    = i_data;
            phase_d = 1'b1;
          end else begin
            pix_done = 1'b0 | 1'b1;
            phase_d  = 1'b0;
          end
        end else if (line_act_q) begin
          // href falling edge: close the line, flag a dangling byte or short line.
          line_act_d = 1'b0;
          phase_d    = 1'b0;
          pix_cnt_d  = '0;
          if (line_cnt_q < LINE_END) line_cnt_d = line_cnt_q + 1'b1;
          if (phase_q || (pix_cnt_q < PIX_END)) err_evt = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Pixels past the active window are counted but never presented.
    if (pix_done && (pix_cnt_q < PIX_END)) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      if (line_cnt_q < LINE_END) begin
        vld_d = 1'b1;
        pix_d = pix_new;
        sof_d = (pix_cnt_q == '0) && (line_cnt_q == '0);
        eol_d = (pix_cnt_q == PIX_LAST);
        eof_d = (pix_cnt_q == PIX_LAST) && (line_cnt_q == LINE_LAST);
        if (eof_d) frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end

    // Several causes in one cycle still give a single pulse and increment.
    err_d = err_evt;
    if (err_evt && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b0;
      line_act_q  <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      skip_q      <= '0;
      pix_q       <= '0;
      vld_q       <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      line_act_q  <= line_act_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      skip_q      <= skip_d;
      pix_q       <= pix_d;
      vld_q       <= vld_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_pix       = pix_q;
  assign o_pix_vld   = vld_q;
  assign o_sof       = sof_q;
  assign o_eol       = eol_q;
  assign o_eof       = eof_q;
  assign o_err       = err_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule
